cordic_hyp_sched: RTL and testbench
===================================

Name: cordic_hyp_sched

Overview:
Issue scheduler for the hyperbolic CORDIC ROM / buffer / cordic-cell pipeline. It arbitrates round-robin among NREQ requesters, drives the ROM index and write-enable strobe one operation per cycle, and caps in-flight operations with a credit counter. It tracks each issued operation through the fixed pipeline latency and reports completion with the requester ID. It sits between the requesting engines and the ROM front end of the pipeline.

Parameters:
NREQ, 2, number of requesters (2..4)
PIPE_LAT, 7, cycles from wen assertion to the result leaving the last cordic cell (ROM 1 + buffer 1 + 5 cell stages)
MAX_OUT, 8, maximum in-flight operations (1..PIPE_LAT+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  scheduler enable; low = stop issuing and drain
req_valid  in  NREQ  per-requester request
req_qua  in  3*NREQ  quadrant index per requester, slice i = [3i+2:3i]
req_cor  in  7*NREQ  cordic ROM index per requester, slice i = [7i+6:7i]
req_ready  out  NREQ  one-hot grant; transfer when valid&ready
index_qua  out  3  registered quadrant index to ROM/buffer
index_cor  out  7  registered ROM index
wen  out  1  one-cycle issue strobe, aligned with index_*
done_valid  out  1  operation completed at pipeline output this cycle
done_id  out  2  requester ID of the completing operation
outstanding  out  4  current in-flight count
idle  out  1  state IDLE and outstanding==0

Behaviour:
- Reset (when reset=1 at a clk edge): state IDLE; rr pointer 0; all outputs 0, including index_qua/index_cor/wen/done_*/outstanding/req_ready. The latency shift register is cleared, so in-flight ops are discarded and produce no done. Reset mid-operation aborts everything.
- FSM:
  - IDLE: if en, go to ISSUE.
  - ISSUE: if !en, go to DRAIN.
  - DRAIN: if en, go to ISSUE; else if outstanding==0 and no issue this cycle, go to IDLE.
- Issue condition, combinational per cycle: state==ISSUE && outstanding<MAX_OUT && any req_valid.
- Arbitration: the winner is the first valid requester at or after the rr pointer, wrapping modulo NREQ. req_ready is driven only to the winner (combinational from req_valid, state, and credit). On issue, rr = winner+1 mod NREQ. A single requester that stays valid is granted every cycle.
- On issue, next clock: index_qua/index_cor = winner's fields, wen=1. Otherwise wen=0 and index_* hold their last value. Issue latency is request to wen in 1 cycle.
- Latency tracker: a PIPE_LAT-deep shift register of {valid,id}; stage 0 is loaded with {wen_next, winner}. done_valid/done_id come from the last stage, so done_valid asserts exactly PIPE_LAT cycles after the wen cycle.
- Credit counter: +1 on issue, -1 on done_valid. Simultaneous issue and done leaves the count unchanged. At outstanding==MAX_OUT, issue is blocked and req_ready=0 even if a done occurs that same cycle; the freed credit is usable the next cycle. The counter never wraps; an assertion fires on underflow or overflow.
- req_valid with en=0: no grant; requests wait, no drop.
- NREQ<4: unused done_id upper bits are 0.

Optional Feature:
CORDIC_HYP_SCHED_STATS_EN
- Defined: adds output stat_issue (16*NREQ), per-requester saturating 16-bit issue counters cleared by reset, and output stat_stall (16), a saturating count of cycles with a valid request blocked only by credit.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package cordic_hyp_pkg: state enum (IDLE/ISSUE/DRAIN), index widths QUA_W=3 and COR_W=7, default PIPE_LAT=7.
- One sub-module, cordic_hyp_rr_arb: parameterised NREQ round-robin arbiter (req, pointer -> one-hot grant, winner ID).
- The latency shift register and credit counter stay inline.

Test Plan:
- Reset then en=1, req0 valid with qua=3'd5, cor=7'd42 for one cycle -> wen high 1 cycle later with index_qua=5, index_cor=42; done_valid with done_id=0 exactly 7 cycles after wen; outstanding goes 0->1->0.
- req0 and req1 both held valid for 6 cycles -> grants alternate 0,1,0,1,0,1; wen every cycle; six dones in the same order.
- MAX_OUT=8 with continuous requests -> 8 back-to-back wens; outstanding stays at 8 until the first done; issue resumes at most one op per cycle after a credit frees; outstanding never exceeds 8.
- en dropped with 3 ops in flight -> DRAIN, no new wen, 3 dones arrive, idle=1 the cycle after outstanding reaches 0.
- reset asserted with 4 ops in flight -> next cycle outstanding=0, wen=0, and no done_valid for the following 10 cycles.
- Macro defined, 5 issues from req1 plus 3 credit-stall cycles -> stat_issue slice 1 reads 5, stat_stall reads 3.

Source files
------------

// File: rtl/cordic_hyp_pkg.sv
// ---------------------------------------------------------------------------
// cordic_hyp_pkg
// Shared definitions for the hyperbolic CORDIC issue scheduler:
//   - index widths for the ROM quadrant / cordic index
//   - scheduler FSM state encoding
//   - default pipeline latency (ROM 1 + buffer 1 + 5 cordic cells)
//   - modular add helper used by the round-robin arbiter
// ---------------------------------------------------------------------------
package cordic_hyp_pkg;

    localparam int QUA_W        = 3;   // quadrant index width
    localparam int COR_W        = 7;   // cordic ROM index width
    localparam int ID_W         = 2;   // requester ID width (up to 4 requesters)
    localparam int CNT_W        = 4;   // in-flight counter width (holds up to 8+)
    localparam int STAT_W       = 16;  // statistics counter width
    localparam int PIPE_LAT_DEF = 7;   // wen -> last cordic cell output

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // (base + off) mod n, for walking requesters starting at the rr pointer
    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/cordic_hyp_rr_arb.sv
// ---------------------------------------------------------------------------
// cordic_hyp_rr_arb
// Combinational round-robin arbiter. The winner is the first asserted request
// at or after the pointer, wrapping modulo NREQ.
// Ports:
//   i_req    [NREQ-1:0]  request vector
//   i_ptr    [ID_W-1:0]  round-robin start position (must be < NREQ)
//   o_grant  [NREQ-1:0]  one-hot grant (all zero when no request)
//   o_winner [ID_W-1:0]  index of the granted requester
//   o_any               at least one request is asserted
// ---------------------------------------------------------------------------
module cordic_hyp_rr_arb
    import cordic_hyp_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_winner,
    output logic            o_any
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_grant  = '0;
        o_winner = '0;
        o_any    = 1'b0;
        // Walk from farthest to nearest so the requester closest to the
        // pointer is written last and therefore wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[wrap_add(int'(i_ptr), k, NREQ)]) begin
                o_any    = 1'b1;
                o_winner = ID_W'(wrap_add(int'(i_ptr), k, NREQ));
            end
        end
        if (o_any) begin
            o_grant[o_winner] = 1'b1;
        end
    end

endmodule

// File: rtl/cordic_hyp_sched.sv
// ---------------------------------------------------------------------------
// cordic_hyp_sched
// Issue scheduler for the hyperbolic CORDIC ROM / buffer / cordic-cell
// pipeline. Round-robin arbitration among NREQ requesters, one issue per
// cycle, in-flight operations capped by a credit counter, completions
// reported PIPE_LAT cycles after the wen strobe with the requester ID.
//
// Optional feature macro: CORDIC_HYP_SCHED_STATS_EN
//   adds stat_issue (per-requester saturating issue counts) and stat_stall
//   (saturating count of cycles blocked only by credit).
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   en                 enable; low stops issuing and drains
//   req_valid/qua/cor  per-requester request and its ROM fields
//   req_ready          one-hot grant (combinational)
//   index_qua/cor, wen registered ROM index and one-cycle issue strobe
//   done_valid/id      completion at the pipeline output and its requester
//   outstanding        in-flight count
//   idle               FSM idle and nothing in flight
// ---------------------------------------------------------------------------
module cordic_hyp_sched
    import cordic_hyp_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int MAX_OUT  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [QUA_W*NREQ-1:0]   req_qua,
    input  logic [COR_W*NREQ-1:0]   req_cor,
    output logic [NREQ-1:0]         req_ready,
    output logic [QUA_W-1:0]        index_qua,
    output logic [COR_W-1:0]        index_cor,
    output logic                    wen,
    output logic                    done_valid,
    output logic [ID_W-1:0]         done_id,
    output logic [CNT_W-1:0]        outstanding,
    output logic                    idle
`ifdef CORDIC_HYP_SCHED_STATS_EN
    ,
    output logic [STAT_W*NREQ-1:0]  stat_issue,
    output logic [STAT_W-1:0]       stat_stall
`endif
);

    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    state_t                         r_state;
    logic [ID_W-1:0]                r_rr;
    logic [QUA_W-1:0]               r_index_qua;
    logic [COR_W-1:0]               r_index_cor;
    logic                           r_wen;
    logic [PIPE_LAT-1:0]            r_pipe_v;
    logic [PIPE_LAT-1:0][ID_W-1:0]  r_pipe_id;
    logic                           r_done_valid;
    logic [ID_W-1:0]                r_done_id;
    logic [CNT_W-1:0]               r_outstanding;

    logic [NREQ-1:0]                w_grant;
    logic [ID_W-1:0]                w_winner;
    logic                           w_any;
    logic                           w_credit_ok;
    logic                           w_issue;
    logic [ID_W-1:0]                w_id_in;

    cordic_hyp_rr_arb #(
        .NREQ     (NREQ)
    ) u_arb (
        .i_req    (req_valid),
        .i_ptr    (r_rr),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Credit is judged on the registered count only: a done in the same
    // cycle frees its slot for the following cycle, not this one.
    assign w_credit_ok = (r_outstanding < MAX_OUT_C);
    // No handshake while reset is high, since the transfer would be discarded.
    assign w_issue     = !reset && (r_state == ISSUE) && w_credit_ok && w_any;
    assign w_id_in     = w_issue ? w_winner : '0;

    assign req_ready   = w_issue ? w_grant : '0;
    assign index_qua   = r_index_qua;
    assign index_cor   = r_index_cor;
    assign wen         = r_wen;
    assign done_valid  = r_done_valid;
    assign done_id     = r_done_id;
    assign outstanding = r_outstanding;
    assign idle        = (r_state == IDLE) && (r_outstanding == '0);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr          <= '0;
            r_index_qua   <= '0;
            r_index_cor   <= '0;
            r_wen         <= 1'b0;
            // NOTE: the latency tracker is reset so in-flight ops never produce a stray done after reset.
            r_pipe_v      <= '0;
            r_pipe_id     <= '0;
            r_done_valid  <= 1'b0;
            r_done_id     <= '0;
            r_outstanding <= '0;
        end else begin
            case (r_state)
                IDLE:    if (en) r_state <= ISSUE;
                ISSUE:   if (!en) r_state <= DRAIN;
                DRAIN: begin
                    if (en)
                        r_state <= ISSUE;
                    else if ((r_outstanding == '0) && !w_issue)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            r_wen <= w_issue;
            if (w_issue) begin
                r_index_qua <= req_qua[int'(w_winner)*QUA_W +: QUA_W];
                r_index_cor <= req_cor[int'(w_winner)*COR_W +: COR_W];
                r_rr        <= (w_winner == ID_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;
            end

            // Stage 0 is loaded alongside wen; done is registered off the last
            // stage so it lands exactly PIPE_LAT cycles after the wen cycle.
            r_pipe_v     <= {r_pipe_v[PIPE_LAT-2:0], w_issue};
            r_pipe_id    <= {r_pipe_id[PIPE_LAT-2:0], w_id_in};
            r_done_valid <= r_pipe_v[PIPE_LAT-1];
            r_done_id    <= r_pipe_id[PIPE_LAT-1];

            case ({w_issue, r_done_valid})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Credit counter must never wrap in either direction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_no_overflow:  assert (!(w_issue && !r_done_valid && (r_outstanding >= MAX_OUT_C)));
            a_no_underflow: assert (!(!w_issue && r_done_valid && (r_outstanding == '0)));
        end
    end

`ifdef CORDIC_HYP_SCHED_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] r_stat_issue;
    logic [STAT_W-1:0]           r_stat_stall;
    logic                        w_credit_stall;

    // A cycle counts as a stall only when credit is the sole blocker.
    assign w_credit_stall = !reset && (r_state == ISSUE) && w_any && !w_credit_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_issue <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_issue && (r_stat_issue[w_winner] != '1))
                r_stat_issue[w_winner] <= r_stat_issue[w_winner] + 1'b1;
            if (w_credit_stall && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_issue = r_stat_issue;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_cordic_hyp_sched.sv
// ---------------------------------------------------------------------------
// tb_cordic_hyp_sched
// Self-checking bench for cordic_hyp_sched. The reference model keeps a log
// of issued operations (issue cycle + requester); wen, done, outstanding and
// the index registers are derived from that log by cycle arithmetic.
// Inputs are driven right after the falling edge, outputs checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_cordic_hyp_sched;

    localparam int NREQ     = 2;
    localparam int PIPE_LAT = 7;
    localparam int MAX_OUT  = 8;
    localparam int QW       = 3;
    localparam int CW       = 7;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   en;
    logic [NREQ-1:0]        req_valid;
    logic [QW*NREQ-1:0]     req_qua;
    logic [CW*NREQ-1:0]     req_cor;
    logic [NREQ-1:0]        req_ready;
    logic [QW-1:0]          index_qua;
    logic [CW-1:0]          index_cor;
    logic                   wen;
    logic                   done_valid;
    logic [1:0]             done_id;
    logic [3:0]             outstanding;
    logic                   idle;
`ifdef CORDIC_HYP_SCHED_STATS_EN
    logic [16*NREQ-1:0]     stat_issue;
    logic [15:0]            stat_stall;
`endif

    cordic_hyp_sched #(
        .NREQ        (NREQ),
        .PIPE_LAT    (PIPE_LAT),
        .MAX_OUT     (MAX_OUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .req_valid   (req_valid),
        .req_qua     (req_qua),
        .req_cor     (req_cor),
        .req_ready   (req_ready),
        .index_qua   (index_qua),
        .index_cor   (index_cor),
        .wen         (wen),
        .done_valid  (done_valid),
        .done_id     (done_id),
        .outstanding (outstanding),
        .idle        (idle)
`ifdef CORDIC_HYP_SCHED_STATS_EN
        ,
        .stat_issue  (stat_issue),
        .stat_stall  (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_ISSUE, M_DRAIN} mstate_t;
    typedef struct {
        int cyc;
        int id;
    } op_t;

    op_t     log_q[$];
    mstate_t m_state   = M_IDLE;
    int      m_rr      = 0;
    int      m_qua     = 0;
    int      m_cor     = 0;
    int      m_last    = -10;   // cycle of the most recent issue
    int      m_stat_issue [NREQ];
    int      m_stat_stall = 0;
    int      cyc       = 0;

    int      n_tests   = 0;
    int      n_fail    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // An op issued in cycle c is in flight from c+1 (wen) through c+1+PIPE_LAT (done).
    function automatic int m_outstanding(input int t);
        int n = 0;
        foreach (log_q[i])
            if (t >= log_q[i].cyc + 1 && t <= log_q[i].cyc + 1 + PIPE_LAT) n++;
        return n;
    endfunction

    task automatic step(input logic rst, input logic e, input logic [NREQ-1:0] v,
                        input logic [QW*NREQ-1:0] q, input logic [CW*NREQ-1:0] c);
        int              o;
        int              win;
        bit              iss;
        bit              dv;
        int              did;
        logic [NREQ-1:0] exp_rdy;

        reset = rst; en = e; req_valid = v; req_qua = q; req_cor = c;
        #1;

        while (log_q.size() > 0 && log_q[0].cyc + PIPE_LAT + 2 < cyc) void'(log_q.pop_front());

        o   = m_outstanding(cyc);
        dv  = 0;
        did = 0;
        foreach (log_q[i])
            if (log_q[i].cyc + 1 + PIPE_LAT == cyc) begin dv = 1; did = log_q[i].id; end

        iss = 0;
        win = 0;
        if (!rst && m_state == M_ISSUE && o < MAX_OUT)
            for (int k = 0; k < NREQ; k++)
                if (!iss && v[(m_rr + k) % NREQ]) begin iss = 1; win = (m_rr + k) % NREQ; end
        exp_rdy = '0;
        if (iss) exp_rdy[win] = 1'b1;

        chk("wen",         wen,         32'(m_last == cyc - 1));
        chk("index_qua",   index_qua,   m_qua);
        chk("index_cor",   index_cor,   m_cor);
        chk("done_valid",  done_valid,  32'(dv));
        if (dv) chk("done_id", done_id, did);
        chk("outstanding", outstanding, o);
        chk("idle",        idle,        32'(m_state == M_IDLE && o == 0));
        chk("req_ready",   req_ready,   exp_rdy);
`ifdef CORDIC_HYP_SCHED_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("stat_issue", stat_issue[16*i +: 16], m_stat_issue[i]);
        chk("stat_stall", stat_stall, m_stat_stall);
`endif

        if (rst) begin
            log_q.delete();
            m_state = M_IDLE; m_rr = 0; m_qua = 0; m_cor = 0; m_last = -10;
            foreach (m_stat_issue[i]) m_stat_issue[i] = 0;
            m_stat_stall = 0;
        end else begin
            if (iss) begin
                log_q.push_back('{cyc: cyc, id: win});
                m_qua  = int'(q[QW*win +: QW]);
                m_cor  = int'(c[CW*win +: CW]);
                m_last = cyc;
                m_rr   = (win + 1) % NREQ;
                if (m_stat_issue[win] < 65535) m_stat_issue[win]++;
            end
            if (m_state == M_ISSUE && v != '0 && o >= MAX_OUT && m_stat_stall < 65535) m_stat_stall++;
            case (m_state)
                M_IDLE:  if (e) m_state = M_ISSUE;
                M_ISSUE: if (!e) m_state = M_DRAIN;
                M_DRAIN: if (e) m_state = M_ISSUE; else if (o == 0) m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic quiet(input logic e, input int n);
        for (int i = 0; i < n; i++) step(1'b0, e, '0, '0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [QW*NREQ-1:0] rq;
        logic [CW*NREQ-1:0] rc;

        foreach (m_stat_issue[i]) m_stat_issue[i] = 0;
        reset = 1'b1; en = 1'b0; req_valid = '0; req_qua = '0; req_cor = '0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, '0, '0, '0);
        step(1'b1, 1'b0, '0, '0, '0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_wen",         wen,         0);
        chk("rst_done",        done_valid,  0);
        chk("rst_idle",        idle,        1);

        // Single op: qua=5, cor=42 from requester 0
        step(1'b0, 1'b1, '0, '0, '0);                               // IDLE -> ISSUE
        step(1'b0, 1'b1, 2'b01, {3'd0, 3'd5}, {7'd0, 7'd42});
        chk("t1_wen",         wen,         1);
        chk("t1_index_qua",   index_qua,   5);
        chk("t1_index_cor",   index_cor,   42);
        chk("t1_outstanding", outstanding, 1);
        quiet(1'b1, PIPE_LAT);
        chk("t1_done_valid",  done_valid,  1);
        chk("t1_done_id",     done_id,     0);
        quiet(1'b1, 1);
        chk("t1_out_back_0",  outstanding, 0);

        // Two requesters held for 6 cycles: alternating grants and dones
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 2'b11, {3'd2, 3'd1}, {7'd100, 7'd7});
        quiet(1'b1, PIPE_LAT + 3);

        // Continuous requests: credit cap at MAX_OUT, then one-per-free-slot
        for (int i = 0; i < 24; i++)
            step(1'b0, 1'b1, 2'b11, 6'(i), 14'(i * 5));
        quiet(1'b1, PIPE_LAT + 3);

        // en dropped with 3 in flight: drain, requests held but not granted
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b01, {3'd0, 3'd3}, {7'd0, 7'd9});
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 2'b11, {3'd4, 3'd3}, {7'd1, 7'd9});
        chk("drain_idle", idle, 1);

        // Reset with 4 in flight: everything discarded, no late dones
        step(1'b0, 1'b1, '0, '0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b11, {3'd6, 3'd7}, {7'd3, 7'd4});
        step(1'b1, 1'b1, 2'b11, '0, '0);
        chk("abort_outstanding", outstanding, 0);
        chk("abort_wen",         wen,         0);
        quiet(1'b0, 10);

        // Single requester 1 held: granted every cycle until credit runs out
        step(1'b0, 1'b1, '0, '0, '0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 2'b10, {3'd5, 3'd0}, {7'(i), 7'd0});
        quiet(1'b1, PIPE_LAT + 3);

        // Randomized traffic with occasional reset and en drops
        for (int i = 0; i < 500; i++) begin
            rq = QW*NREQ'($urandom);
            rc = CW*NREQ'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                 NREQ'($urandom), rq, rc);
        end
        quiet(1'b0, PIPE_LAT + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
